// File: rtl/issue_sb_pkg.sv
// Shared types for the issue stage: operand selects, unit/op encodings and the
// registered control part of an issue packet.
package issue_sb_pkg;

  typedef enum logic [1:0] {
    OP_A_REG    = 2'd0,
    OP_A_IMM    = 2'd1,
    OP_A_CURRPC = 2'd2
  } op_a_sel;

  typedef enum logic {
    OP_B_REG = 1'b0,
    OP_B_IMM = 1'b1
  } op_b_sel;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op;

  typedef enum logic [2:0] {
    PC_JAL  = 3'd0,
    PC_JALR = 3'd1,
    PC_BEQ  = 3'd2,
    PC_BNE  = 3'd3,
    PC_BLT  = 3'd4,
    PC_BGE  = 3'd5,
    PC_BLTU = 3'd6,
    PC_BGEU = 3'd7
  } pc_op;

  typedef enum logic [1:0] {
    EXU_ALU = 2'd0,
    EXU_PC  = 2'd1,
    EXU_LSU = 2'd2
  } exu_sel;

  // Width-independent control fields; datapath fields live next to it in the top.
  typedef struct packed {
    exu_sel unit;
    alu_op  alu;
    pc_op   pcop;
    logic   lsu_we;
    logic   rd_we;
    logic   rd_src;
  } issue_pkt_t;

  function automatic issue_pkt_t build_ctl(input exu_sel unit, input alu_op aop,
                                           input pc_op pop, input logic lsu_we,
                                           input logic rd_we, input logic rd_nz);
    issue_pkt_t c;
    c.unit   = unit;
    c.alu    = (unit == EXU_ALU) ? aop : ALU_ADD;
    c.pcop   = pop;
    c.lsu_we = (unit == EXU_LSU) & lsu_we;
    c.rd_src = (unit == EXU_LSU) & ~lsu_we;
    // Stores and branches never write the register file.
    c.rd_we  = rd_we & rd_nz & ~c.lsu_we &
               ~((unit == EXU_PC) & (pop != PC_JAL) & (pop != PC_JALR));
    return c;
  endfunction

endpackage

// File: rtl/issue_sb_if.sv
// Decode-side, issue-side and writeback signals of the issue stage, bundled.
interface issue_sb_if
  import issue_sb_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 16
) ();
  localparam int AW = $clog2(NREG);

  logic             dec_valid_i;
  logic             dec_ready_o;
  logic [AW-1:0]    rs1_addr_i, rs2_addr_i, rd_addr_i;
  logic             rs1_used_i, rs2_used_i, rd_we_i;
  logic [XLEN-1:0]  rf_rdata_a_i, rf_rdata_b_i;
  logic [XLEN-1:0]  pc_i, imm_i;
  op_a_sel          op_a_sel_i;
  op_b_sel          op_b_sel_i;
  exu_sel           unit_i;
  alu_op            alu_op_i;
  pc_op             pc_op_i;
  logic             lsu_we_i;

  logic             iss_valid_o;
  logic             iss_ready_i;
  exu_sel           iss_unit_o;
  alu_op            alu_op_o;
  pc_op             pc_op_o;
  logic [XLEN-1:0]  operand_a_o, operand_b_o, pc_o, lsu_wdata_o;
  logic             lsu_we_o, rd_we_o, rd_src_o;
  logic [AW-1:0]    rd_addr_o;

  logic             wb_valid_i;
  logic [AW-1:0]    wb_addr_i;
  logic [XLEN-1:0]  wb_data_i;
  logic             flush_i;
  logic             busy_o;
  logic [CNT_W-1:0] stall_cnt_o;

  modport slave (
    input  dec_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i, rs1_used_i, rs2_used_i,
           rd_we_i, rf_rdata_a_i, rf_rdata_b_i, pc_i, imm_i, op_a_sel_i, op_b_sel_i,
           unit_i, alu_op_i, pc_op_i, lsu_we_i, iss_ready_i, wb_valid_i, wb_addr_i,
           wb_data_i, flush_i,
    output dec_ready_o, iss_valid_o, iss_unit_o, alu_op_o, pc_op_o, operand_a_o,
           operand_b_o, pc_o, lsu_wdata_o, lsu_we_o, rd_we_o, rd_src_o, rd_addr_o,
           busy_o, stall_cnt_o
  );

  modport master (
    output dec_valid_i, rs1_addr_i, rs2_addr_i, rd_addr_i, rs1_used_i, rs2_used_i,
           rd_we_i, rf_rdata_a_i, rf_rdata_b_i, pc_i, imm_i, op_a_sel_i, op_b_sel_i,
           unit_i, alu_op_i, pc_op_i, lsu_we_i, iss_ready_i, wb_valid_i, wb_addr_i,
           wb_data_i, flush_i,
    input  dec_ready_o, iss_valid_o, iss_unit_o, alu_op_o, pc_op_o, operand_a_o,
           operand_b_o, pc_o, lsu_wdata_o, lsu_we_o, rd_we_o, rd_src_o, rd_addr_o,
           busy_o, stall_cnt_o
  );
endinterface

// File: rtl/issue_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, x0 never pending.
module issue_scoreboard #(
  parameter int NREG   = 32,
  parameter int AW     = $clog2(NREG),
  parameter bit BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic [AW-1:0] rd_addr,
  input  logic          rs1_used,
  input  logic          rs2_used,
  input  logic          rd_we,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          wb_valid,
  input  logic [AW-1:0] wb_addr,
  input  logic          flush_clr,
  input  logic [AW-1:0] flush_addr,
  output logic          haz_rs1,
  output logic          haz_rs2,
  output logic          haz_rd,
  output logic          busy
);
  logic [NREG-1:0] pend, pend_nxt, eff_pend, set_vec, clr_vec, wb_vec;

  always_comb begin
    set_vec = '0;
    wb_vec  = '0;
    clr_vec = '0;
    if (set_en)    set_vec[set_addr]   = 1'b1;
    if (wb_valid)  wb_vec[wb_addr]     = 1'b1;
    if (flush_clr) clr_vec[flush_addr] = 1'b1;
    // Without bypass the writeback data is not forwarded, so it cannot unblock this cycle.
    eff_pend = BYPASS ? (pend & ~wb_vec) : pend;
    pend_nxt = (pend & ~(wb_vec | clr_vec)) | set_vec;
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend <= '0;
    else     pend <= pend_nxt;
  end

  assign haz_rs1 = rs1_used & eff_pend[rs1_addr];
  assign haz_rs2 = rs2_used & eff_pend[rs2_addr];
  assign haz_rd  = rd_we & (rd_addr != '0) & eff_pend[rd_addr];
  assign busy    = |pend;
endmodule

// File: rtl/issue_sb.sv
// Issue stage: hazard check against the scoreboard, operand select with writeback
// bypass, one registered issue packet with valid/ready, flush and a stall counter.
module issue_sb
  import issue_sb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int NREG   = 32,
  parameter bit BYPASS = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  issue_sb_if.slave  bus
);
  localparam int AW = $clog2(NREG);

  logic             haz_rs1, haz_rs2, haz_rd, busy, dec_ready, accept, flush_clr;
  logic [XLEN-1:0]  src1_p0, src2_p0, opa_p0, opb_p0, wdata_p0;
  issue_pkt_t       ctl_p0, ctl_p1;
  logic             vld_p1;
  logic [XLEN-1:0]  opa_p1, opb_p1, pc_p1, wdata_p1;
  logic [AW-1:0]    rd_p1;
  logic [CNT_W-1:0] stall_cnt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  issue_scoreboard #(.NREG(NREG), .AW(AW), .BYPASS(BYPASS)) u_sb (
    .clk       (clk_i),
    .rst       (rst_i),
    .rs1_addr  (bus.rs1_addr_i),
    .rs2_addr  (bus.rs2_addr_i),
    .rd_addr   (bus.rd_addr_i),
    .rs1_used  (bus.rs1_used_i),
    .rs2_used  (bus.rs2_used_i),
    .rd_we     (bus.rd_we_i),
    .set_en    (accept & ctl_p0.rd_we),
    .set_addr  (bus.rd_addr_i),
    .wb_valid  (bus.wb_valid_i),
    .wb_addr   (bus.wb_addr_i),
    .flush_clr (flush_clr),
    .flush_addr(rd_p1),
    .haz_rs1   (haz_rs1),
    .haz_rs2   (haz_rs2),
    .haz_rd    (haz_rd),
    .busy      (busy)
  );

  assign dec_ready = ~(haz_rs1 | haz_rs2 | haz_rd) & ~bus.flush_i & (~vld_p1 | bus.iss_ready_i);
  assign accept    = bus.dec_valid_i & dec_ready;
  // Only a packet still sitting in the register owns its pending bit on flush.
  assign flush_clr = bus.flush_i & vld_p1 & ~bus.iss_ready_i & ctl_p1.rd_we;

  // Stage p0: operand select and packet build from decode inputs
  always_comb begin
    src1_p0 = bus.rf_rdata_a_i;
    src2_p0 = bus.rf_rdata_b_i;
    if (BYPASS && bus.wb_valid_i && (bus.wb_addr_i == bus.rs1_addr_i) && (bus.rs1_addr_i != '0))
      src1_p0 = bus.wb_data_i;
    if (BYPASS && bus.wb_valid_i && (bus.wb_addr_i == bus.rs2_addr_i) && (bus.rs2_addr_i != '0))
      src2_p0 = bus.wb_data_i;
    case (bus.op_a_sel_i)
      OP_A_REG:    opa_p0 = src1_p0;
      OP_A_CURRPC: opa_p0 = bus.pc_i;
      default:     opa_p0 = '0;
    endcase
    opb_p0   = (bus.op_b_sel_i == OP_B_IMM) ? bus.imm_i : src2_p0;
    ctl_p0   = build_ctl(bus.unit_i, bus.alu_op_i, bus.pc_op_i, bus.lsu_we_i,
                         bus.rd_we_i, bus.rd_addr_i != '0);
    wdata_p0 = ctl_p0.lsu_we ? src2_p0 : '0;
  end

  // Stage p1: registered issue packet
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      ctl_p1   <= '0;
      opa_p1   <= '0;
      opb_p1   <= '0;
      pc_p1    <= '0;
      wdata_p1 <= '0;
      rd_p1    <= '0;
    end else if (bus.flush_i) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1   <= 1'b1;
      ctl_p1   <= ctl_p0;
      opa_p1   <= opa_p0;
      opb_p1   <= opb_p0;
      pc_p1    <= bus.pc_i;
      wdata_p1 <= wdata_p0;
      rd_p1    <= bus.rd_addr_i;
    end else if (bus.iss_ready_i) begin
      vld_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                             stall_cnt <= '0;
    else if (bus.dec_valid_i & ~dec_ready) stall_cnt <= sat_inc(stall_cnt);
  end

  assign bus.dec_ready_o = dec_ready;
  assign bus.iss_valid_o = vld_p1;
  assign bus.iss_unit_o  = ctl_p1.unit;
  assign bus.alu_op_o    = ctl_p1.alu;
  assign bus.pc_op_o     = ctl_p1.pcop;
  assign bus.operand_a_o = opa_p1;
  assign bus.operand_b_o = opb_p1;
  assign bus.pc_o        = pc_p1;
  assign bus.lsu_wdata_o = wdata_p1;
  assign bus.lsu_we_o    = ctl_p1.lsu_we;
  assign bus.rd_we_o     = ctl_p1.rd_we;
  assign bus.rd_src_o    = ctl_p1.rd_src;
  assign bus.rd_addr_o   = rd_p1;
  assign bus.busy_o      = busy;
  assign bus.stall_cnt_o = stall_cnt;
endmodule

// File: tb/tb_issue_sb.sv
// Scoreboard bench for issue_sb: directed scenarios followed by random traffic,
// checked against a queue-based packet model and a per-register pending array.
module tb_issue_sb;
  import issue_sb_pkg::*;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW = 5;
  localparam int CNT_W = 16;
  localparam bit BYPASS = 1'b1;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  issue_sb_if #(.XLEN(XLEN), .NREG(NREG), .CNT_W(CNT_W)) bus ();

  issue_sb #(.XLEN(XLEN), .NREG(NREG), .BYPASS(BYPASS), .CNT_W(CNT_W)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  typedef struct {
    exu_sel          unit;
    alu_op           aop;
    pc_op            pop;
    logic [XLEN-1:0] a, b, pc, wd;
    logic            lsu_we, rd_we, rd_src;
    logic [AW-1:0]   rd;
  } pkt_t;

  pkt_t        q[$];
  bit          mpend[NREG];
  int unsigned mcnt;
  int          checks = 0;
  int          failures = 0;
  bit          mon_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic bit any_pend();
    bit r = 1'b0;
    for (int i = 0; i < NREG; i++) r |= mpend[i];
    return r;
  endfunction

  function automatic bit eff(input logic [AW-1:0] r);
    return mpend[r] && !(BYPASS && bus.wb_valid_i && bus.wb_addr_i == r);
  endfunction

  // Expected packet straight from the operand/flag rules
  function automatic pkt_t model_pkt();
    pkt_t p;
    logic [XLEN-1:0] s1, s2;
    s1 = bus.rf_rdata_a_i;
    s2 = bus.rf_rdata_b_i;
    if (BYPASS && bus.wb_valid_i && bus.wb_addr_i == bus.rs1_addr_i && bus.rs1_addr_i != 0) s1 = bus.wb_data_i;
    if (BYPASS && bus.wb_valid_i && bus.wb_addr_i == bus.rs2_addr_i && bus.rs2_addr_i != 0) s2 = bus.wb_data_i;
    if (bus.op_a_sel_i == OP_A_REG) p.a = s1;
    else if (bus.op_a_sel_i == OP_A_CURRPC) p.a = bus.pc_i;
    else p.a = '0;
    p.b      = (bus.op_b_sel_i == OP_B_REG) ? s2 : bus.imm_i;
    p.unit   = bus.unit_i;
    p.aop    = (bus.unit_i == EXU_ALU) ? bus.alu_op_i : ALU_ADD;
    p.pop    = bus.pc_op_i;
    p.pc     = bus.pc_i;
    p.lsu_we = (bus.unit_i == EXU_LSU) && bus.lsu_we_i;
    p.wd     = p.lsu_we ? s2 : '0;
    p.rd_src = (bus.unit_i == EXU_LSU) && !bus.lsu_we_i;
    p.rd_we  = bus.rd_we_i && bus.rd_addr_i != 0;
    if (p.lsu_we) p.rd_we = 1'b0;
    if (bus.unit_i == EXU_PC && bus.pc_op_i != PC_JAL && bus.pc_op_i != PC_JALR) p.rd_we = 1'b0;
    p.rd = bus.rd_addr_i;
    return p;
  endfunction

  // Monitor: compares the presented packet and status, retires taken/squashed packets
  always @(negedge clk) begin
    if (mon_en) begin
      chk("iss_valid", 64'(bus.iss_valid_o), 64'(q.size() != 0));
      if (q.size() != 0 && bus.iss_valid_o) begin
        chk("iss_unit", 64'(bus.iss_unit_o), 64'(q[0].unit));
        chk("alu_op", 64'(bus.alu_op_o), 64'(q[0].aop));
        chk("pc_op", 64'(bus.pc_op_o), 64'(q[0].pop));
        chk("operand_a", 64'(bus.operand_a_o), 64'(q[0].a));
        chk("operand_b", 64'(bus.operand_b_o), 64'(q[0].b));
        chk("pc", 64'(bus.pc_o), 64'(q[0].pc));
        chk("lsu_wdata", 64'(bus.lsu_wdata_o), 64'(q[0].wd));
        chk("lsu_we", 64'(bus.lsu_we_o), 64'(q[0].lsu_we));
        chk("rd_we", 64'(bus.rd_we_o), 64'(q[0].rd_we));
        chk("rd_src", 64'(bus.rd_src_o), 64'(q[0].rd_src));
        chk("rd_addr", 64'(bus.rd_addr_o), 64'(q[0].rd));
      end
      chk("busy", 64'(bus.busy_o), 64'(any_pend()));
      chk("stall_cnt", 64'(bus.stall_cnt_o), 64'(mcnt));
      if (q.size() != 0) begin
        if (bus.flush_i && !bus.iss_ready_i) begin
          if (q[0].rd_we) mpend[q[0].rd] = 1'b0;
          void'(q.pop_front());
        end else if (bus.iss_ready_i) begin
          void'(q.pop_front());
        end
      end
    end
  end

  // Called at posedge+1 with inputs set; checks ready, updates model, returns at next posedge+1
  task automatic tick();
    bit   hz, exp_rdy, acc;
    pkt_t p;
    #5;
    hz = (bus.rs1_used_i && eff(bus.rs1_addr_i)) || (bus.rs2_used_i && eff(bus.rs2_addr_i)) ||
         (bus.rd_we_i && bus.rd_addr_i != 0 && eff(bus.rd_addr_i));
    exp_rdy = !hz && !bus.flush_i && (q.size() == 0 || bus.iss_ready_i);
    chk("dec_ready", 64'(bus.dec_ready_o), 64'(exp_rdy));
    acc = bus.dec_valid_i && exp_rdy;
    p = model_pkt();
    if (acc) q.push_back(p);
    if (bus.dec_valid_i && !exp_rdy && mcnt != CNT_MAX) mcnt++;
    if (bus.wb_valid_i) mpend[bus.wb_addr_i] = 1'b0;
    if (acc && p.rd_we) mpend[p.rd] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_valid_i  = 1'b0;
    bus.rs1_addr_i   = '0;
    bus.rs2_addr_i   = '0;
    bus.rd_addr_i    = '0;
    bus.rs1_used_i   = 1'b0;
    bus.rs2_used_i   = 1'b0;
    bus.rd_we_i      = 1'b0;
    bus.rf_rdata_a_i = '0;
    bus.rf_rdata_b_i = '0;
    bus.pc_i         = '0;
    bus.imm_i        = '0;
    bus.op_a_sel_i   = OP_A_REG;
    bus.op_b_sel_i   = OP_B_REG;
    bus.unit_i       = EXU_ALU;
    bus.alu_op_i     = ALU_ADD;
    bus.pc_op_i      = PC_JAL;
    bus.lsu_we_i     = 1'b0;
    bus.iss_ready_i  = 1'b0;
    bus.wb_valid_i   = 1'b0;
    bus.wb_addr_i    = '0;
    bus.wb_data_i    = '0;
    bus.flush_i      = 1'b0;
  endtask

  task automatic instr(input exu_sel u, input int rs1, input bit u1, input int rs2,
                       input bit u2, input int rd, input bit we);
    bus.dec_valid_i  = 1'b1;
    bus.unit_i       = u;
    bus.rs1_addr_i   = AW'(rs1);
    bus.rs2_addr_i   = AW'(rs2);
    bus.rd_addr_i    = AW'(rd);
    bus.rs1_used_i   = u1;
    bus.rs2_used_i   = u2;
    bus.rd_we_i      = we;
    bus.rf_rdata_a_i = $urandom;
    bus.rf_rdata_b_i = $urandom;
    bus.pc_i         = $urandom;
    bus.imm_i        = $urandom;
    bus.op_a_sel_i   = OP_A_REG;
    bus.op_b_sel_i   = OP_B_REG;
    bus.alu_op_i     = ALU_ADD;
    bus.pc_op_i      = PC_JAL;
    bus.lsu_we_i     = 1'b0;
  endtask

  task automatic clear_model();
    q.delete();
    for (int i = 0; i < NREG; i++) mpend[i] = 1'b0;
    mcnt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic rand_inputs();
    bus.dec_valid_i  = ($urandom % 4) != 0;
    bus.unit_i       = exu_sel'($urandom_range(0, 2));
    bus.rs1_addr_i   = AW'($urandom_range(0, 7));
    bus.rs2_addr_i   = AW'($urandom_range(0, 7));
    bus.rd_addr_i    = AW'($urandom_range(0, 7));
    bus.rs1_used_i   = $urandom % 2;
    bus.rs2_used_i   = $urandom % 2;
    bus.rd_we_i      = $urandom % 2;
    bus.rf_rdata_a_i = $urandom;
    bus.rf_rdata_b_i = $urandom;
    bus.pc_i         = $urandom;
    bus.imm_i        = $urandom;
    bus.op_a_sel_i   = op_a_sel'($urandom_range(0, 2));
    bus.op_b_sel_i   = op_b_sel'($urandom_range(0, 1));
    bus.alu_op_i     = alu_op'($urandom_range(0, 9));
    bus.pc_op_i      = pc_op'($urandom_range(0, 7));
    bus.lsu_we_i     = $urandom % 2;
    bus.iss_ready_i  = ($urandom % 4) != 0;
    bus.wb_valid_i   = ($urandom % 3) == 0;
    bus.wb_addr_i    = AW'($urandom_range(0, 7));
    bus.wb_data_i    = $urandom;
    bus.flush_i      = ($urandom % 16) == 0;
  endtask

  initial begin
    clear_model();
    idle();
    do_reset();
    mon_en = 1'b1;

    // Independent back-to-back ALU ops
    for (int k = 1; k <= 4; k++) begin
      instr(EXU_ALU, 0, 1'b0, 0, 1'b0, k, 1'b1);
      bus.alu_op_i    = ALU_XOR;
      bus.iss_ready_i = 1'b1;
      tick();
      chk("indep_valid", 64'(bus.iss_valid_o), 64'd1);
    end
    idle();
    bus.iss_ready_i = 1'b1;
    tick();
    chk("indep_stall_cnt", 64'(bus.stall_cnt_o), 64'd0);

    // RAW stall then bypassed writeback
    do_reset();
    instr(EXU_ALU, 0, 1'b0, 0, 1'b0, 5, 1'b1);
    bus.iss_ready_i = 1'b1;
    tick();
    instr(EXU_ALU, 5, 1'b1, 1, 1'b1, 6, 1'b1);
    bus.iss_ready_i = 1'b1;
    repeat (3) tick();
    chk("raw_stall_cnt", 64'(bus.stall_cnt_o), 64'd3);
    bus.wb_valid_i = 1'b1;
    bus.wb_addr_i  = AW'(5);
    bus.wb_data_i  = 32'h1234;
    tick();
    chk("raw_bypass_opa", 64'(bus.operand_a_o), 64'h1234);
    idle();
    bus.iss_ready_i = 1'b1;
    tick();

    // Back-pressure holds the packet
    do_reset();
    instr(EXU_ALU, 0, 1'b0, 0, 1'b0, 1, 1'b1);
    bus.op_a_sel_i  = OP_A_CURRPC;
    bus.pc_i        = 32'h100;
    bus.iss_ready_i = 1'b1;
    tick();
    instr(EXU_ALU, 0, 1'b0, 0, 1'b0, 2, 1'b1);
    bus.iss_ready_i = 1'b0;
    repeat (2) begin
      chk("bp_ready", 64'(bus.dec_ready_o), 64'd0);
      tick();
      chk("bp_pc_held", 64'(bus.pc_o), 64'h100);
    end
    bus.iss_ready_i = 1'b1;
    tick();
    idle();
    bus.iss_ready_i = 1'b1;
    tick();

    // WAW stall, then writeback coinciding with accept keeps x7 pending
    do_reset();
    instr(EXU_ALU, 0, 1'b0, 0, 1'b0, 7, 1'b1);
    bus.iss_ready_i = 1'b1;
    tick();
    instr(EXU_ALU, 0, 1'b0, 0, 1'b0, 7, 1'b1);
    bus.iss_ready_i = 1'b1;
    tick();
    bus.wb_valid_i = 1'b1;
    bus.wb_addr_i  = AW'(7);
    tick();
    idle();
    bus.iss_ready_i = 1'b1;
    tick();
    chk("waw_busy", 64'(bus.busy_o), 64'd1);

    // Flush squashes an untaken load to x9
    do_reset();
    instr(EXU_LSU, 1, 1'b1, 0, 1'b0, 9, 1'b1);
    tick();
    idle();
    bus.flush_i = 1'b1;
    tick();
    chk("flush_valid", 64'(bus.iss_valid_o), 64'd0);
    chk("flush_busy", 64'(bus.busy_o), 64'd0);
    idle();
    tick();

    // rd = x0 never writes or sets pending
    do_reset();
    instr(EXU_ALU, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    bus.iss_ready_i = 1'b1;
    tick();
    chk("x0_valid", 64'(bus.iss_valid_o), 64'd1);
    chk("x0_rd_we", 64'(bus.rd_we_o), 64'd0);
    chk("x0_busy", 64'(bus.busy_o), 64'd0);
    idle();
    bus.iss_ready_i = 1'b1;
    tick();

    // Asynchronous reset while stalled
    do_reset();
    instr(EXU_ALU, 0, 1'b0, 0, 1'b0, 3, 1'b1);
    bus.alu_op_i   = ALU_SUB;
    bus.op_a_sel_i = OP_A_CURRPC;
    bus.pc_i       = 32'h200;
    tick();
    instr(EXU_ALU, 3, 1'b1, 0, 1'b0, 4, 1'b1);
    repeat (2) tick();
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    chk("rst_valid", 64'(bus.iss_valid_o), 64'd0);
    chk("rst_alu_op", 64'(bus.alu_op_o), 64'(ALU_ADD));
    chk("rst_opa", 64'(bus.operand_a_o), 64'd0);
    chk("rst_pc", 64'(bus.pc_o), 64'd0);
    chk("rst_rd_we", 64'(bus.rd_we_o), 64'd0);
    chk("rst_busy", 64'(bus.busy_o), 64'd0);
    chk("rst_stall_cnt", 64'(bus.stall_cnt_o), 64'd0);
    do_reset();

    // Random traffic
    repeat (1500) begin
      rand_inputs();
      tick();
    end
    idle();
    bus.iss_ready_i = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
